mem_arb_n: RTL and testbench

MEM_ARB_N -- requirements
Module: mem_arb_n

---
 rtl/mem_arb_n.sv | 181 ++++++++++++++++++
 tb/tb_mem_arb_n.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_arb_n.sv
// rtl/mem_arb_n.sv - N-channel memory arbiter with round-robin or fixed priority and completion timeout
module mem_arb_n #(
  parameter int NUM_REQ     = 4,
  parameter int LINE_SIZE   = 512,
  parameter int ADDR_W      = 32,
  parameter int FIXED_PRIO  = 0,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_wr,
  input  logic [NUM_REQ*ADDR_W-1:0]     req_addr,
  input  logic [NUM_REQ*LINE_SIZE-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]            req_grant,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic                          rsp_err,
  output logic [LINE_SIZE-1:0]          rsp_rdata,
  output logic [1:0]                    op,
  output logic [ADDR_W-1:0]             io_addr,
  output logic [LINE_SIZE-1:0]          common_data_bus_out,
  input  logic [LINE_SIZE-1:0]          common_data_bus_in,
  input  logic                          rd_valid,
  input  logic                          tx_done,
  output logic                          busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [1:0] OP_IDLE = 2'b00;
  localparam logic [1:0] OP_RD   = 2'b01;
  localparam logic [1:0] OP_WR   = 2'b10;

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;

  state_t                 state_q, state_d;
  logic [NUM_REQ-1:0]     grant_q, grant_d;
  logic [NUM_REQ-1:0]     rsp_valid_q, rsp_valid_d;
  logic                   rsp_err_q, rsp_err_d;
  logic [LINE_SIZE-1:0]   rdata_q, rdata_d;
  logic [1:0]             op_q, op_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [LINE_SIZE-1:0]   wdata_q, wdata_d;
  logic [IDX_W-1:0]       sel_q, sel_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [TO_W-1:0]        tcnt_q, tcnt_d;
  logic [IDX_W-1:0]       pick;

  // Round-robin scans upward from the channel after the last grant.
  function automatic logic [IDX_W-1:0] pick_chan(input logic [NUM_REQ-1:0] v,
                                                 input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] r;
    logic             found;
    int               idx;
    r     = '0;
    found = 1'b0;
    if (FIXED_PRIO != 0) begin
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        if (v[i]) r = IDX_W'(i);
      end
    end else begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        idx = (int'(ptr) + k) % NUM_REQ;
        if (!found && v[idx]) begin
          r     = IDX_W'(idx);
          found = 1'b1;
        end
      end
    end
    return r;
  endfunction

  assign pick = pick_chan(req_valid, ptr_q);

  always_comb begin
    state_d     = state_q;
    grant_d     = '0;
    rsp_valid_d = '0;
    rsp_err_d   = 1'b0;
    rdata_d     = rdata_q;
    op_d        = op_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    sel_d       = sel_q;
    ptr_d       = ptr_q;
    tcnt_d      = tcnt_q;
    case (state_q)
      IDLE: begin
        op_d = OP_IDLE;
        // The cycle carrying a response is kept grant-free.
        if (|req_valid && !(|rsp_valid_q)) begin
          sel_d         = pick;
          ptr_d         = pick;
          grant_d[pick] = 1'b1;
          addr_d        = req_addr[int'(pick)*ADDR_W +: ADDR_W];
          wdata_d       = req_wdata[int'(pick)*LINE_SIZE +: LINE_SIZE];
          tcnt_d        = '0;
          if (req_wr[pick]) begin
            state_d = WR_WAIT;
            op_d    = OP_WR;
          end else begin
            state_d = RD_WAIT;
            op_d    = OP_RD;
          end
        end
      end
      RD_WAIT: begin
        if (rd_valid) begin
          rdata_d            = common_data_bus_in;
          rsp_valid_d[sel_q] = 1'b1;
          state_d            = IDLE;
          op_d               = OP_IDLE;
        end else if (tcnt_q == TO_LAST) begin
          rsp_valid_d[sel_q] = 1'b1;
          rsp_err_d          = 1'b1;
          state_d            = IDLE;
          op_d               = OP_IDLE;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      WR_WAIT: begin
        if (tx_done) begin
          rsp_valid_d[sel_q] = 1'b1;
          state_d            = IDLE;
          op_d               = OP_IDLE;
        end else if (tcnt_q == TO_LAST) begin
          rsp_valid_d[sel_q] = 1'b1;
          rsp_err_d          = 1'b1;
          state_d            = IDLE;
          op_d               = OP_IDLE;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        op_d    = OP_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      rsp_valid_q <= '0;
      rsp_err_q   <= 1'b0;
      rdata_q     <= '0;
      op_q        <= OP_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      sel_q       <= '0;
      ptr_q       <= IDX_W'(NUM_REQ - 1);
      tcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rdata_q     <= rdata_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      sel_q       <= sel_d;
      ptr_q       <= ptr_d;
      tcnt_q      <= tcnt_d;
    end
  end

  assign req_grant           = grant_q;
  assign rsp_valid           = rsp_valid_q;
  assign rsp_err             = rsp_err_q;
  assign rsp_rdata           = rdata_q;
  assign op                  = op_q;
  assign io_addr             = addr_q;
  assign common_data_bus_out = wdata_q;
  assign busy                = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arb_n.sv
// tb/tb_mem_arb_n.sv - directed-vector bench for mem_arb_n (round-robin and fixed-priority instances)
module tb_mem_arb_n;
  localparam int N  = 4;
  localparam int LS = 64;
  localparam int AW = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_wr = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*LS-1:0] req_wdata = '0;
  logic [LS-1:0]   cdb_in = '0;
  logic            rd_valid = 1'b0;
  logic            tx_done = 1'b0;

  logic [N-1:0]  r_grant, r_rsp, f_grant, f_rsp;
  logic          r_err, f_err, r_busy, f_busy;
  logic [LS-1:0] r_rdata, f_rdata, r_cdb, f_cdb;
  logic [1:0]    r_op, f_op;
  logic [AW-1:0] r_addr, f_addr;

  int vectors = 0;
  int miscompares = 0;
  logic [LS-1:0] last_rd;

  localparam logic [LS-1:0] DA5 = 64'hA5A5_A5A5_A5A5_A5A5;
  localparam logic [LS-1:0] D5A = 64'h5A5A_5A5A_5A5A_5A5A;
  localparam logic [LS-1:0] D3C = 64'h3C3C_0000_1234_5678;

  always #5 clk = ~clk;

  mem_arb_n #(.NUM_REQ(N), .LINE_SIZE(LS), .ADDR_W(AW), .FIXED_PRIO(0), .TIMEOUT_CYC(16)) dut_rr (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_grant(r_grant), .rsp_valid(r_rsp), .rsp_err(r_err),
    .rsp_rdata(r_rdata), .op(r_op), .io_addr(r_addr), .common_data_bus_out(r_cdb),
    .common_data_bus_in(cdb_in), .rd_valid(rd_valid), .tx_done(tx_done), .busy(r_busy));

  mem_arb_n #(.NUM_REQ(N), .LINE_SIZE(LS), .ADDR_W(AW), .FIXED_PRIO(1), .TIMEOUT_CYC(16)) dut_fx (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_grant(f_grant), .rsp_valid(f_rsp), .rsp_err(f_err),
    .rsp_rdata(f_rdata), .op(f_op), .io_addr(f_addr), .common_data_bus_out(f_cdb),
    .common_data_bus_in(cdb_in), .rd_valid(rd_valid), .tx_done(tx_done), .busy(f_busy));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int rr_order[5];
    rr_order = '{0, 1, 2, 3, 0};

    // Reset state
    step();
    step();
    chk("rst_op", 64'(r_op), 64'd0);
    chk("rst_busy", 64'(r_busy), 64'd0);
    chk("rst_grant", 64'(r_grant), 64'd0);
    chk("rst_rsp", 64'(r_rsp), 64'd0);
    chk("rst_rdata", r_rdata, 64'd0);
    chk("rst_addr", 64'(r_addr), 64'd0);
    rst = 1'b1;

    // Round-robin vs fixed priority, all channels reading continuously
    req_valid = 4'b1111;
    req_wr    = 4'b0000;
    for (int g = 0; g < 5; g++) begin
      step();
      chk($sformatf("rr_grant%0d", g), 64'(r_grant), 64'(4'b0001 << rr_order[g]));
      chk($sformatf("fx_grant%0d", g), 64'(f_grant), 64'd1);
      rd_valid = 1'b1;
      cdb_in   = DA5;
      step();
      chk($sformatf("rr_rsp%0d", g), 64'(r_rsp), 64'(4'b0001 << rr_order[g]));
      chk($sformatf("fx_rsp%0d", g), 64'(f_rsp), 64'd1);
      rd_valid = 1'b0;
      step();
      chk($sformatf("rr_gap%0d", g), 64'(r_grant), 64'd0);
    end
    last_rd   = DA5;
    req_valid = '0;
    step();

    // Single read on ch2, with ignored tx_done and changed request fields in flight
    req_valid = 4'b0100;
    req_addr[2*AW +: AW] = 32'h0000_1000;
    step();
    chk("rd_grant", 64'(r_grant), 64'b0100);
    chk("rd_op", 64'(r_op), 64'b01);
    chk("rd_addr", 64'(r_addr), 64'h1000);
    chk("rd_busy", 64'(r_busy), 64'd1);
    req_valid = '0;
    req_addr[2*AW +: AW] = 32'hDEAD_BEEF;
    tx_done = 1'b1;
    step();
    chk("rd_txdone_ign", 64'(r_rsp), 64'd0);
    chk("rd_addr_hold", 64'(r_addr), 64'h1000);
    chk("rd_op_hold", 64'(r_op), 64'b01);
    tx_done  = 1'b0;
    rd_valid = 1'b1;
    cdb_in   = D3C;
    step();
    chk("rd_rsp", 64'(r_rsp), 64'b0100);
    chk("rd_err", 64'(r_err), 64'd0);
    chk("rd_rdata", r_rdata, D3C);
    chk("rd_op_idle", 64'(r_op), 64'd0);
    rd_valid = 1'b0;
    last_rd  = D3C;
    step();

    // Write on ch1, rd_valid in WR_WAIT ignored
    req_valid = 4'b0010;
    req_wr    = 4'b0010;
    req_addr[1*AW +: AW] = 32'h0000_2040;
    req_wdata[1*LS +: LS] = '1;
    step();
    chk("wr_grant", 64'(r_grant), 64'b0010);
    chk("wr_op", 64'(r_op), 64'b10);
    chk("wr_addr", 64'(r_addr), 64'h2040);
    chk("wr_cdb", r_cdb, {LS{1'b1}});
    req_valid = '0;
    req_wr    = '0;
    rd_valid  = 1'b1;
    cdb_in    = D5A;
    step();
    chk("wr_rdvalid_ign", 64'(r_rsp), 64'd0);
    rd_valid = 1'b0;
    tx_done  = 1'b1;
    step();
    chk("wr_rsp", 64'(r_rsp), 64'b0010);
    chk("wr_err", 64'(r_err), 64'd0);
    chk("wr_rdata_keep", r_rdata, last_rd);
    tx_done = 1'b0;
    step();

    // Timeout on a ch3 read: response 16 cycles after WAIT entry
    req_valid = 4'b1000;
    req_addr[3*AW +: AW] = 32'h0000_3000;
    step();
    chk("to_grant", 64'(r_grant), 64'b1000);
    req_valid = '0;
    for (int c = 1; c < 16; c++) step();
    chk("to_early", 64'(r_rsp), 64'd0);
    chk("to_busy", 64'(r_busy), 64'd1);
    req_valid = 4'b0001;
    step();
    chk("to_rsp", 64'(r_rsp), 64'b1000);
    chk("to_err", 64'(r_err), 64'd1);
    chk("to_rdata_keep", r_rdata, last_rd);
    chk("to_op", 64'(r_op), 64'd0);
    step();
    chk("to_nogrant_rsp_cycle", 64'(r_grant), 64'd0);
    step();
    chk("to_next_grant", 64'(r_grant), 64'b0001);
    req_valid = '0;
    rd_valid  = 1'b1;
    cdb_in    = D5A;
    step();
    chk("to_next_rsp", 64'(r_rsp), 64'b0001);
    chk("to_next_rdata", r_rdata, D5A);
    rd_valid = 1'b0;
    step();

    // Completion and timeout in the same cycle: completion wins
    req_valid = 4'b0001;
    step();
    chk("tie_grant", 64'(r_grant), 64'b0001);
    req_valid = '0;
    for (int c = 1; c < 16; c++) step();
    rd_valid = 1'b1;
    cdb_in   = DA5;
    step();
    chk("tie_rsp", 64'(r_rsp), 64'b0001);
    chk("tie_err", 64'(r_err), 64'd0);
    chk("tie_rdata", r_rdata, DA5);
    rd_valid = 1'b0;
    step();

    // Reset in the middle of a ch2 read
    req_valid = 4'b0100;
    step();
    chk("mr_grant", 64'(r_grant), 64'b0100);
    req_valid = '0;
    step();
    rst = 1'b0;
    #1;
    chk("mr_op_async", 64'(r_op), 64'd0);
    chk("mr_busy_async", 64'(r_busy), 64'd0);
    rd_valid = 1'b1;
    step();
    chk("mr_no_rsp", 64'(r_rsp), 64'd0);
    rd_valid  = 1'b0;
    rst       = 1'b1;
    req_valid = 4'b1001;
    step();
    chk("mr_first_grant", 64'(r_grant), 64'b0001);
    chk("mr_no_rsp2", 64'(r_rsp), 64'd0);
    req_valid = '0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
